gray_step_mon: RTL and testbench

Downstream monitor for the 4-bit Gray code counter: samples the counter's Gray output, converts it to binary, and classifies every change as a legal ±1 step or an illegal jump. It tracks direction and wrap-around, and declares lock after a run of consecutive legal steps. It counts illegal steps in a saturating error counter. It sits directly on the counter's `q` bus and feeds status and debug logic in the same clock domain.

---
 rtl/gray_step_mon.sv | 147 ++++++++++++++
 tb/tb_gray_step_mon.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_mon.sv
// Monitors a Gray-coded counter bus: converts each sample to binary, classifies
// the step as hold / +1 / -1 / illegal, and tracks lock, direction, wrap and errors.
module gray_step_mon #(
    parameter int W        = 4,
    parameter int LOCK_RUN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W-1:0]     g_in,
    input  logic             clr_err,
    output logic [W-1:0]     bin,
    output logic             dir_up,
    output logic             wrap,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             locked,
    output logic [1:0]       state
);

    localparam int RUN_W = $clog2(LOCK_RUN + 1);

    typedef enum logic [1:0] {
        UNLK = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    logic [W-1:0]     g_s_reg;
    logic             s_v_reg;
    logic [W-1:0]     bin_reg,   bin_next;
    logic             dir_reg,   dir_next;
    logic             wrap_reg,  wrap_next;
    logic             serr_reg,  serr_next;
    logic [ERR_W-1:0] err_reg,   err_next;
    logic [RUN_W-1:0] run_reg,   run_next;
    state_t           state_reg, state_next;

    logic [W-1:0]     b;
    logic [RUN_W-1:0] run_inc;
    logic             is_hold, is_up, is_dn, err_inc;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_g2b
            assign b[gi] = ^g_s_reg[W-1:gi];
        end
    endgenerate

    assign is_hold = (b == bin_reg);
    assign is_up   = (b == bin_reg + W'(1));
    assign is_dn   = (b == bin_reg - W'(1));
    assign run_inc = run_reg + RUN_W'(1);

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        dir_next   = dir_reg;
        run_next   = run_reg;
        wrap_next  = 1'b0;
        serr_next  = 1'b0;
        err_inc    = 1'b0;
        if (s_v_reg) begin
            case (state_reg)
                UNLK: begin
                    bin_next   = b;
                    run_next   = '0;
                    state_next = ACQ;
                end
                ACQ: begin
                    if (!is_hold) begin
                        bin_next = b;
                        if (is_up || is_dn) begin
                            dir_next = is_up;
                            run_next = run_inc;
                            if (run_inc == RUN_W'(LOCK_RUN)) begin
                                state_next = LOCK;
                            end
                        end else begin
                            run_next = '0;
                        end
                    end
                end
                LOCK: begin
                    if (!is_hold) begin
                        bin_next = b;
                        if (is_up || is_dn) begin
                            dir_next  = is_up;
                            wrap_next = is_up ? (b == '0) : (b == '1);
                        end else begin
                            serr_next  = 1'b1;
                            err_inc    = 1'b1;
                            run_next   = '0;
                            state_next = ACQ;
                        end
                    end
                end
                default: state_next = UNLK;
            endcase
        end

        // Clear has priority over a same-edge increment.
        if (clr_err) begin
            err_next = '0;
        end else if (err_inc && (err_reg != '1)) begin
            err_next = err_reg + ERR_W'(1);
        end else begin
            err_next = err_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_s_reg   <= '0;
            s_v_reg   <= 1'b0;
            bin_reg   <= '0;
            dir_reg   <= 1'b1;
            wrap_reg  <= 1'b0;
            serr_reg  <= 1'b0;
            err_reg   <= '0;
            run_reg   <= '0;
            state_reg <= UNLK;
        end else begin
            if (en) begin
                g_s_reg <= g_in;
            end
            s_v_reg   <= en;
            bin_reg   <= bin_next;
            dir_reg   <= dir_next;
            wrap_reg  <= wrap_next;
            serr_reg  <= serr_next;
            err_reg   <= err_next;
            run_reg   <= run_next;
            state_reg <= state_next;
        end
    end

    assign bin      = bin_reg;
    assign dir_up   = dir_reg;
    assign wrap     = wrap_reg;
    assign step_err = serr_reg;
    assign err_cnt  = err_reg;
    assign locked   = (state_reg == LOCK);
    assign state    = state_reg;

endmodule

// File: tb/tb_gray_step_mon.sv
// Directed bench for gray_step_mon: a behavioural model pushes expected outputs
// per driven cycle, which are popped and compared once the DUT has produced them.
module tb_gray_step_mon;

    localparam int W    = 4;
    localparam int LR   = 4;
    localparam int EW   = 2;
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  g_in = '0;
    logic [W-1:0]  bin;
    logic          dir_up, wrap, step_err, locked;
    logic [EW-1:0] err_cnt;
    logic [1:0]    state;

    gray_step_mon #(.W(W), .LOCK_RUN(LR), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .en(en), .g_in(g_in), .clr_err(clr_err),
        .bin(bin), .dir_up(dir_up), .wrap(wrap), .step_err(step_err),
        .err_cnt(err_cnt), .locked(locked), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0]  bin;
        logic          dir;
        logic          wrap;
        logic          serr;
        logic [EW-1:0] err;
        logic          locked;
        logic [1:0]    state;
    } exp_t;
    exp_t exp_q[$];

    int m_bin, m_dir, m_wrap, m_serr, m_err, m_state, m_run, m_pv, m_pg;

    function automatic int g2b(input int g);
        int r = 0;
        for (int i = 0; i < W; i++) r ^= (g >> i);
        return r & MASK;
    endfunction

    function automatic logic [W-1:0] gray(input int v);
        int m = v & MASK;
        return W'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_bin = 0; m_dir = 1; m_wrap = 0; m_serr = 0; m_err = 0;
        m_state = 0; m_run = 0; m_pv = 0; m_pg = 0;
    endtask

    // Effect of one rising edge: evaluate the pending stage-1 sample, apply clear.
    task automatic model_edge(input logic c);
        int b, d;
        bit inc;
        inc = 0; m_wrap = 0; m_serr = 0;
        if (m_pv != 0) begin
            b = g2b(m_pg);
            d = (b - m_bin) & MASK;
            if (m_state == 0) begin
                m_bin = b; m_run = 0; m_state = 1;
            end else if (d == 1 || d == MASK) begin
                m_dir = (d == 1) ? 1 : 0;
                if (m_state == 2) begin
                    m_wrap = (d == 1) ? int'(b == 0) : int'(b == MASK);
                end else begin
                    m_run++;
                    if (m_run == LR) m_state = 2;
                end
                m_bin = b;
            end else if (d != 0) begin
                m_bin = b; m_run = 0;
                if (m_state == 2) begin m_serr = 1; inc = 1; end
                m_state = 1;
            end
        end
        if (c) m_err = 0;
        else if (inc && m_err < (1 << EW) - 1) m_err++;
    endtask

    task automatic step(input logic e, input logic [W-1:0] g, input logic c);
        exp_t x;
        en = e; g_in = g; clr_err = c;
        model_edge(c);
        m_pv = int'(e); m_pg = int'(g);
        x.bin = m_bin[W-1:0]; x.dir = m_dir[0]; x.wrap = m_wrap[0];
        x.serr = m_serr[0]; x.err = m_err[EW-1:0];
        x.locked = (m_state == 2); x.state = m_state[1:0];
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = exp_q.pop_front();
        chk("sb_bin", 32'(bin), 32'(x.bin));
        chk("sb_dir_up", 32'(dir_up), 32'(x.dir));
        chk("sb_wrap", 32'(wrap), 32'(x.wrap));
        chk("sb_step_err", 32'(step_err), 32'(x.serr));
        chk("sb_err_cnt", 32'(err_cnt), 32'(x.err));
        chk("sb_locked", 32'(locked), 32'(x.locked));
        chk("sb_state", 32'(state), 32'(x.state));
        $display("t=%0t en=%0b g=%b clr=%0b -> bin=%0d dir=%0b wrap=%0b serr=%0b err=%0d lock=%0b st=%0d",
                 $time, e, g, c, bin, dir_up, wrap, step_err, err_cnt, locked, state);
    endtask

    task automatic stepv(input int v, input logic c);
        step(1'b1, gray(v), c);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bin"}, 32'(bin), 0);
        chk({tag, "_dir_up"}, 32'(dir_up), 1);
        chk({tag, "_wrap"}, 32'(wrap), 0);
        chk({tag, "_step_err"}, 32'(step_err), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom_range(0, 1));
            g_in = W'($urandom);
            @(negedge clk);
            chk_reset_vals("rst_hold");
        end
        rst = 1'b1;
        model_reset();

        // Forward count from release
        stepv(0, 0);
        stepv(1, 0);
        chk("first_state", 32'(state), 1);
        chk("first_err", 32'(err_cnt), 0);
        for (int v = 2; v <= 4; v++) stepv(v, 0);
        chk("no_early_lock", 32'(locked), 0);
        stepv(5, 0);
        chk("lock_5th", 32'(locked), 1);
        chk("lock_bin", 32'(bin), 4);
        for (int v = 6; v <= 17; v++) stepv(v, 0);
        chk("up_wrap", 32'(wrap), 1);
        chk("up_wrap_dir", 32'(dir_up), 1);
        chk("up_wrap_bin", 32'(bin), 0);
        stepv(2, 0);
        chk("wrap_drop", 32'(wrap), 0);

        // Reverse while locked
        stepv(1, 0); stepv(0, 0); stepv(15, 0); stepv(14, 0);
        chk("dn_wrap_bin", 32'(bin), 15);
        chk("dn_wrap", 32'(wrap), 1);
        chk("dn_wrap_dir", 32'(dir_up), 0);
        for (int v = 13; v >= 2; v--) stepv(v, 0);
        stepv(4, 0);
        chk("pre_jump_bin", 32'(bin), 2);

        // Illegal jump 0011 -> 0110 while locked
        stepv(5, 0);
        chk("jump_serr", 32'(step_err), 1);
        chk("jump_err", 32'(err_cnt), 1);
        chk("jump_locked", 32'(locked), 0);
        chk("jump_state", 32'(state), 1);
        chk("jump_bin", 32'(bin), 4);
        stepv(6, 0);
        chk("serr_drop", 32'(step_err), 0);
        stepv(7, 0); stepv(8, 0); stepv(9, 0);
        chk("relock", 32'(locked), 1);

        // Gaps and holds
        for (int i = 0; i < 3; i++) step(1'b0, gray(9), 1'b0);
        for (int i = 0; i < 3; i++) stepv(9, 0);
        chk("hold_locked", 32'(locked), 1);
        chk("hold_bin", 32'(bin), 9);
        chk("hold_serr", 32'(step_err), 0);
        for (int v = 8; v >= 1; v--) stepv(v, 0);
        stepv(14, 0);
        stepv(13, 0);
        chk("onebit_serr", 32'(step_err), 1);
        chk("onebit_err", 32'(err_cnt), 2);

        // Saturation and clear
        for (int v = 12; v >= 9; v--) stepv(v, 0);
        stepv(3, 0); stepv(4, 0);
        chk("err3_serr", 32'(step_err), 1);
        chk("err3_cnt", 32'(err_cnt), 3);
        for (int v = 5; v <= 8; v++) stepv(v, 0);
        stepv(0, 0); stepv(1, 0);
        chk("sat_serr", 32'(step_err), 1);
        chk("sat_cnt", 32'(err_cnt), 3);
        for (int v = 2; v <= 5; v++) stepv(v, 0);
        stepv(11, 0);
        stepv(12, 1);
        chk("clr_wins_serr", 32'(step_err), 1);
        chk("clr_wins_cnt", 32'(err_cnt), 0);
        stepv(13, 0);
        chk("after_clr_cnt", 32'(err_cnt), 0);

        // Asynchronous reset mid-operation, with a sample already in stage 1
        en = 1'b1; g_in = gray(14); clr_err = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1'b0, '0, 1'b0);
        chk("s1_flushed", 32'(state), 0);
        stepv(5, 0); stepv(6, 0);
        chk("post_rst_state", 32'(state), 1);
        chk("post_rst_bin", 32'(bin), 5);
        for (int v = 7; v <= 10; v++) stepv(v, 0);
        chk("post_rst_lock", 32'(locked), 1);
        step(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
